// File: rtl/acc_cpu_core_if.sv
// Programming handshake between an external loader (master) and acc_cpu_core (slave).
// The master streams words on prog_data/prog_valid while holding prog_en;
// the core answers with prog_ready per word and prog_done once the RAM is full.
interface acc_cpu_core_if #(
    parameter int DATA_W = 8
);
    logic              prog_en;
    logic              prog_valid;
    logic [DATA_W-1:0] prog_data;
    logic              prog_ready;
    logic              prog_done;

    modport master (
        output prog_en,
        output prog_valid,
        output prog_data,
        input  prog_ready,
        input  prog_done
    );

    modport slave (
        input  prog_en,
        input  prog_valid,
        input  prog_data,
        output prog_ready,
        output prog_done
    );
endinterface

// File: rtl/acc_cpu_core.sv
// acc_cpu_core: accumulator CPU with internal program/data RAM, a sequential
// loader and a two-cycle fetch/execute FSM (FETCH, EXEC, HALT, PROG).
// Optional macro ACC_CPU_CALL_EN adds CALL (opcode A) / RET (opcode B) with a
// single return-address register; without it those opcodes behave as NOP.
module acc_cpu_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    acc_cpu_core_if.slave     prog,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              carry,
    output logic              zero,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_dbg
);
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;
    localparam logic [1:0] S_PROG  = 2'd3;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
`ifdef ACC_CPU_CALL_EN
    localparam logic [3:0] OP_CAL = 4'hA;
    localparam logic [3:0] OP_RET = 4'hB;
`endif
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic              carry_q, carry_d;
    logic              zero_q, zero_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              prog_done_q, prog_done_d;
`ifdef ACC_CPU_CALL_EN
    logic [ADDR_W-1:0] ret_q, ret_d;
`endif

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] mem_op;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] diff;
    logic              ready;

    assign opcode  = ir_q[DATA_W-1 -: 4];
    assign operand = ir_q[ADDR_W-1:0];
    assign imm     = {4'b0000, ir_q[DATA_W-5:0]};
    assign mem_op  = mem_q[operand];
    assign sum     = {1'b0, a_q} + {1'b0, mem_op};
    assign diff    = a_q - mem_op;
    // Loader accepts words only while still programming and the RAM is not full
    assign ready   = (state_q == S_PROG) && prog.prog_en && !cnt_q[ADDR_W];

    assign prog.prog_ready = ready;
    assign prog.prog_done  = prog_done_q;
    assign out_data        = out_data_q;
    assign out_valid       = out_valid_q;
    assign carry           = carry_q;
    assign zero            = zero_q;
    assign halted          = (state_q == S_HALT);
    assign pc_dbg          = pc_q;

    // Next-state logic for the FSM, datapath registers and RAM write port
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        a_d         = a_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        cnt_d       = cnt_q;
        prog_done_d = prog_done_q;
`ifdef ACC_CPU_CALL_EN
        ret_d       = ret_q;
`endif
        mem_we      = 1'b0;
        mem_waddr   = operand;
        mem_wdata   = a_q;

        case (state_q)
            S_FETCH: begin
                if (prog.prog_en) begin
                    state_d = S_PROG;
                    cnt_d   = '0;
                end else begin
                    ir_d    = mem_q[pc_q];
                    pc_d    = pc_q + 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (opcode)
                    OP_LDA: a_d = mem_op;
                    OP_ADD: begin
                        a_d     = sum[DATA_W-1:0];
                        carry_d = sum[DATA_W];
                        zero_d  = (sum[DATA_W-1:0] == '0);
                    end
                    OP_SUB: begin
                        a_d     = diff;
                        carry_d = (a_q >= mem_op);
                        zero_d  = (diff == '0);
                    end
                    OP_STA: mem_we = 1'b1;
                    OP_LDI: a_d = imm;
                    OP_JMP: pc_d = operand;
                    OP_JC:  if (carry_q) pc_d = operand;
                    OP_JZ:  if (zero_q) pc_d = operand;
`ifdef ACC_CPU_CALL_EN
                    OP_CAL: begin
                        ret_d = pc_q;
                        pc_d  = operand;
                    end
                    OP_RET: pc_d = ret_q;
`endif
                    OP_OUT: begin
                        out_data_d  = a_q;
                        out_valid_d = 1'b1;
                    end
                    OP_HLT: state_d = S_HALT;
                    default: ;
                endcase
            end
            S_HALT: begin
                if (prog.prog_en) begin
                    state_d = S_PROG;
                    cnt_d   = '0;
                end
            end
            default: begin
                // Leaving PROG restarts execution from address 0 with whatever image is loaded
                if (!prog.prog_en) begin
                    state_d     = S_FETCH;
                    pc_d        = '0;
                    a_d         = '0;
                    carry_d     = 1'b0;
                    zero_d      = 1'b0;
                    prog_done_d = 1'b0;
                end else if (prog.prog_valid && ready) begin
                    mem_we      = 1'b1;
                    mem_waddr   = cnt_q[ADDR_W-1:0];
                    mem_wdata   = prog.prog_data;
                    cnt_d       = cnt_q + 1'b1;
                    prog_done_d = (cnt_q[ADDR_W-1:0] == {ADDR_W{1'b1}});
                end
            end
        endcase
    end

    // Control and architectural state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            prog_done_q <= 1'b0;
`ifdef ACC_CPU_CALL_EN
            ret_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            prog_done_q <= prog_done_d;
`ifdef ACC_CPU_CALL_EN
            ret_q       <= ret_d;
`endif
        end
    end

    // RAM write port shared by the loader and STA; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end
endmodule

// File: doc/acc_cpu_core.md
Name: acc_cpu_core

Overview:
- Parametrised successor to the 8-bit bus-based accumulator CPU, with the SAP datapath collapsed into one synchronous core.
- Contains internal program/data RAM, a sequential loader, and a fetch/execute FSM.
- Data width and address depth are generalised; adds conditional jumps, an immediate load, a programming handshake and a halt state.
- Sits directly under the TinyTapeout top wrapper, replacing the separate PC/IR/MAR/RAM/ALU/register instances.

Parameters:
- DATA_W, 8, word width of RAM, accumulator, B operand and output register; must be >= ADDR_W+4.
- ADDR_W, 4, RAM address width; depth = 2**ADDR_W words.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- prog_en  in  1  request programming mode.
- prog_valid  in  1  prog_data holds a valid word.
- prog_data  in  DATA_W  word to load.
- prog_ready  out  1  loader accepts a word this cycle.
- prog_done  out  1  all 2**ADDR_W words loaded.
- out_data  out  DATA_W  output register.
- out_valid  out  1  one-cycle pulse when out_data is updated.
- carry  out  1  carry flag.
- zero  out  1  zero flag.
- halted  out  1  core in HALT.
- pc_dbg  out  ADDR_W  current program counter.

Behaviour:
- Instruction format: opcode = word[DATA_W-1 -: 4]; operand = word[ADDR_W-1:0]. The immediate for LDI is word[DATA_W-5:0], zero-extended.
- Reset (rst=1 at the clock edge):
  - PC, A, carry, zero, out_data, out_valid, load counter, prog_done all cleared to 0.
  - State becomes FETCH.
  - RAM is not cleared.
  - rst dominates every other input.
- States: FETCH, EXEC, HALT, PROG.
- FETCH:
  - If prog_en=1, go to PROG (load counter=0).
  - Otherwise IR<=mem[PC], PC<=PC+1 (wraps 2**ADDR_W-1 -> 0), go to EXEC.
- EXEC (one cycle, then FETCH unless noted):
  - 0 NOP.
  - 1 LDA: A<=mem[op].
  - 2 ADD: {carry,A}<=A+mem[op].
  - 3 SUB: A<=A-mem[op]; carry<=1 when no borrow (A>=mem[op]).
  - 4 STA: mem[op]<=A.
  - 5 LDI: A<=imm.
  - 6 JMP: PC<=op.
  - 7 JC: PC<=op if carry.
  - 8 JZ: PC<=op if zero.
  - E OUT: out_data<=A; out_valid=1 next cycle only.
  - F HLT: go to HALT.
  - All other opcodes act as NOP.
- Flags:
  - zero<=(result==0) on ADD/SUB only.
  - Flags hold across all other instructions.
  - Arithmetic is modulo 2**DATA_W.
- Timing: every instruction takes exactly 2 cycles (FETCH+EXEC).
- prog_en asserted during EXEC takes effect at the next FETCH; an instruction in progress always completes.
- HALT:
  - halted=1; PC, A and flags frozen.
  - Exits only via rst, or prog_en=1 -> PROG.
- PROG:
  - prog_ready=1 while load counter < depth.
  - On prog_valid&prog_ready: mem[cnt]<=prog_data, cnt++.
  - After the last word: prog_ready=0, prog_done=1 (level), further words ignored.
  - On prog_en=0 (including mid-load, leaving a partial image): PC, A, flags and prog_done cleared; go to FETCH on the next cycle.
- pc_dbg is the registered PC, directly.

Optional Feature:
- Macro: ACC_CPU_CALL_EN.
- Defined:
  - Opcode A CALL: ret<=PC; PC<=op.
  - Opcode B RET: PC<=ret.
  - ret is a single ADDR_W-bit register, reset to 0.
  - A nested CALL overwrites ret.
- Undefined: opcodes A and B are NOP and no ret register exists.

Test Plan:
- Load (DATA_W=8, ADDR_W=4):
  - Stimulus: prog_en=1, stream 16 words with prog_valid gaps.
  - Required: prog_ready drops after word 16; prog_done=1; a 17th word is ignored; mem matches.
- Arithmetic: program LDA 14; ADD 15; OUT; HLT with mem[14]=0xF0, mem[15]=0x20 -> out_data=0x10, carry=1, zero=0, single out_valid pulse, halted=1 after 8 cycles.
- Subtract/branch: LDI 3; STA 15; SUB 15; JZ 6; OUT; HLT; (6) LDI 9; OUT -> zero=1, carry=1, JZ taken, out_data=0x09, no 0x00 output.
- Wrap-around: PC reaching 15 with NOP at 15 -> next fetch from address 0; pc_dbg shows 0.
- Reset/programming mid-operation:
  - rst during EXEC of ADD: A and flags = 0, PC = 0 next cycle, RAM retained.
  - prog_en dropped after 5 words: core runs from PC 0 with the partial image.
- With ACC_CPU_CALL_EN: CALL 10, then RET at address 10 -> execution resumes at the address after CALL. Without the macro the same image treats A/B as NOP.
